// File: rtl/lsu_if.sv
// Bus bundle for load_store_unit: pipeline request/response channel plus the
// data-memory strobes. The LSU sits on the slave side of this interface.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_fault;

  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        mem_ready;

  logic        busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_address, mem_write_data, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_address, mem_write_data, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ISSUE -> WAIT -> RESP with a
// wait-cycle timeout. Define LSU_RANGE_CHECK_EN to fault addresses outside 0x1xxx.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        timeout;
  logic        range_fault;
  logic        op_write;
  logic [7:0]  wait_cnt;

  // Next-state decode; the strobes and flags below are derived from it so
  // every output can be registered in step with the state.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    timeout     = 1'b0;
    range_fault = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = ISSUE;
`ifdef LSU_RANGE_CHECK_EN
          if (bus.req_addr[15:12] != 4'b0001) begin
            range_fault = 1'b1;
            next_state  = RESP;
          end
`endif
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (bus.mem_ready) begin
          next_state = RESP;
        end else if (wait_cnt + 8'd1 == TIMEOUT_LIMIT) begin
          timeout    = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Handshake and memory strobes mirror next_state so they line up with the
  // state they describe while still coming straight out of flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.req_ready      <= 1'b1;
      bus.busy           <= 1'b0;
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.resp_valid     <= 1'b0;
      op_write           <= 1'b0;
    end else begin
      bus.req_ready  <= (next_state == IDLE);
      bus.busy       <= (next_state != IDLE);
      bus.mem_read   <= (next_state == ISSUE) && !bus.req_write;
      bus.mem_write  <= (next_state == ISSUE) &&  bus.req_write;
      bus.resp_valid <= (next_state == RESP);
      if (accept) begin
        op_write           <= bus.req_write;
        bus.mem_address    <= bus.req_addr;
        bus.mem_write_data <= bus.req_wdata;
      end
    end
  end

  // Wait counter clears when a request enters ISSUE and counts stalled WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !bus.mem_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Response payload is written only on the way into RESP and held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.resp_rdata <= '0;
      bus.resp_fault <= 1'b0;
    end else if (state == WAIT && bus.mem_ready) begin
      bus.resp_rdata <= op_write ? 16'h0000 : bus.mem_read_data;
      bus.resp_fault <= 1'b0;
    end else if (timeout || range_fault) begin
      bus.resp_rdata <= '0;
      bus.resp_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level timing model,
// memory model, per-cycle compare process and directed literal checks.
module tb_load_store_unit;
  localparam int T = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  lsu_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          e;       // cycle index of ISSUE (or RESP for a range fault)
    int          r;       // cycle index of RESP
    bit          issued;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          fault;
    int          d;       // WAIT cycles with mem_ready low before it rises
  } txn_t;

  txn_t        txq[$];
  logic [15:0] ref_mem [65536];
  logic [15:0] dev_mem [65536];
  logic [15:0] rd_buf = 16'h0000;
  int          last_r = -1;
  logic [15:0] hold_rdata = 16'h0000;
  bit          hold_fault = 1'b0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Memory device: writes on the strobe edge, read data available from the next cycle.
  always @(posedge clk) begin
    if (bus.mem_write) dev_mem[bus.mem_address] <= bus.mem_write_data;
    if (bus.mem_read)  rd_buf <= dev_mem[bus.mem_address];
  end

  // mem_ready follows each transaction's planned stall; noise elsewhere.
  initial begin
    bus.mem_ready     = 1'b0;
    bus.mem_read_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (txq.size() > 0 && txq[0].issued && cyc >= txq[0].e + 1 && cyc <= txq[0].r)
        bus.mem_ready = (cyc >= txq[0].e + 1 + txq[0].d);
      else
        bus.mem_ready = 1'($urandom);
      bus.mem_read_data = bus.mem_ready ? rd_buf : 16'($urandom);
    end
  end

  task automatic compare_cycle();
    bit   act = 1'b0;
    bit   exp_rd = 1'b0;
    bit   exp_wr = 1'b0;
    bit   exp_rv = 1'b0;
    txn_t t;
    if (txq.size() > 0 && txq[0].e <= cyc) begin
      act = 1'b1;
      t   = txq[0];
      exp_rd = t.issued && !t.wr && cyc == t.e;
      exp_wr = t.issued &&  t.wr && cyc == t.e;
      exp_rv = (cyc == t.r);
      if (exp_rv) begin
        hold_rdata = t.rdata;
        hold_fault = t.fault;
      end
    end
    check("busy",       32'(bus.busy),       32'(act));
    check("req_ready",  32'(bus.req_ready),  32'(!act));
    check("mem_read",   32'(bus.mem_read),   32'(exp_rd));
    check("mem_write",  32'(bus.mem_write),  32'(exp_wr));
    check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    check("resp_rdata", 32'(bus.resp_rdata), 32'(hold_rdata));
    check("resp_fault", 32'(bus.resp_fault), 32'(hold_fault));
    if (exp_rd || exp_wr) check("mem_address", 32'(bus.mem_address), 32'(t.addr));
    if (exp_wr) check("mem_write_data", 32'(bus.mem_write_data), 32'(t.wdata));
    if (act && exp_rv) void'(txq.pop_front());
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) compare_cycle();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  // Presents a request, schedules its expected timeline and returns in its ISSUE cycle.
  task automatic issue_req(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input int d, output txn_t t);
    int s;
    bit oor = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    s = (cyc > last_r) ? cyc : last_r + 1;
    t.e = s + 1;
    t.wr = wr;
    t.addr = addr;
    t.wdata = wdata;
    t.d = d;
`ifdef LSU_RANGE_CHECK_EN
    oor = (addr[15:12] != 4'h1);
`endif
    if (oor) begin
      t.issued = 1'b0;
      t.r      = t.e;
      t.fault  = 1'b1;
      t.rdata  = 16'h0000;
    end else begin
      t.issued = 1'b1;
      if (wr) ref_mem[addr] = wdata;
      if (d < T) begin
        t.r     = t.e + 2 + d;
        t.fault = 1'b0;
        t.rdata = wr ? 16'h0000 : ref_mem[addr];
      end else begin
        t.r     = t.e + 1 + T;
        t.fault = 1'b1;
        t.rdata = 16'h0000;
      end
    end
    last_r = t.r;
    txq.push_back(t);
    while (cyc < t.e) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready),      32'd1);
    check({tag, "_busy"},       32'(bus.busy),           32'd0);
    check({tag, "_mem_read"},   32'(bus.mem_read),       32'd0);
    check({tag, "_mem_write"},  32'(bus.mem_write),      32'd0);
    check({tag, "_mem_addr"},   32'(bus.mem_address),    32'd0);
    check({tag, "_mem_wdata"},  32'(bus.mem_write_data), 32'd0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid),     32'd0);
    check({tag, "_resp_rdata"}, 32'(bus.resp_rdata),     32'd0);
    check({tag, "_resp_fault"}, 32'(bus.resp_fault),     32'd0);
  endtask

  initial begin
    txn_t t;
    txn_t t1;
    int   s;
    for (int a = 0; a < 65536; a++) begin
      ref_mem[a] = 16'(a * 7) ^ 16'h5A3C;
      dev_mem[a] = 16'(a * 7) ^ 16'h5A3C;
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;

    step(3);
    check_reset_vals("reset");
    reset  = 1'b0;
    chk_en = 1'b1;

    // Store then load at 0x1004; the store is presented in the release cycle.
    s = cyc;
    issue_req(1'b1, 16'h1004, 16'h1234, 0, t);
    at_cycle(s + 1);
    check("st_mem_write", 32'(bus.mem_write),      32'd1);
    check("st_mem_read",  32'(bus.mem_read),       32'd0);
    check("st_addr",      32'(bus.mem_address),    32'h1004);
    check("st_wdata",     32'(bus.mem_write_data), 32'h1234);
    issue_req(1'b0, 16'h1004, 16'h0000, 0, t);
    s = cyc;
    at_cycle(s);
    check("ld_mem_read",  32'(bus.mem_read),    32'd1);
    check("ld_addr",      32'(bus.mem_address), 32'h1004);
    at_cycle(s + 1);
    check("ld_no_resp_early", 32'(bus.resp_valid), 32'd0);
    at_cycle(s + 2);
    check("ld_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("ld_rdata",      32'(bus.resp_rdata), 32'h1234);
    check("ld_fault",      32'(bus.resp_fault), 32'd0);

    // Load stalled for 5 WAIT cycles.
    issue_req(1'b1, 16'h1008, 16'hBEEF, 0, t);
    issue_req(1'b0, 16'h1008, 16'h0000, 5, t);
    s = cyc;
    at_cycle(s + 6);
    check("stall_no_resp", 32'(bus.resp_valid), 32'd0);
    at_cycle(s + 7);
    check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("stall_rdata",      32'(bus.resp_rdata), 32'hBEEF);
    check("stall_fault",      32'(bus.resp_fault), 32'd0);

    // Load with mem_ready stuck low times out after 15 WAIT cycles.
    issue_req(1'b0, 16'h100C, 16'h0000, 255, t);
    s = cyc;
    at_cycle(s + 15);
    check("to_busy",       32'(bus.busy),       32'd1);
    check("to_no_resp",    32'(bus.resp_valid), 32'd0);
    at_cycle(s + 16);
    check("to_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("to_fault",      32'(bus.resp_fault), 32'd1);
    check("to_rdata",      32'(bus.resp_rdata), 32'd0);

    // Address outside the 0x1xxx window.
    issue_req(1'b0, 16'h2000, 16'h0000, 0, t);
    s = cyc;
    at_cycle(s);
`ifdef LSU_RANGE_CHECK_EN
    check("oor_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("oor_fault",      32'(bus.resp_fault), 32'd1);
    check("oor_mem_read",   32'(bus.mem_read),   32'd0);
`else
    check("oor_mem_read",   32'(bus.mem_read),    32'd1);
    check("oor_addr",       32'(bus.mem_address), 32'h2000);
`endif

    // Three back-to-back loads with req_valid held high.
    issue_req(1'b0, 16'h1001, 16'h0000, 0, t1);
    issue_req(1'b0, 16'h1002, 16'h0000, 0, t);
    at_cycle(t1.e + 4);
    check("b2b_second_issue", 32'(bus.mem_read), 32'd1);
    issue_req(1'b0, 16'h1003, 16'h0000, 0, t);
    at_cycle(t1.e + 8);
    check("b2b_third_issue", 32'(bus.mem_read), 32'd1);

    // Reset asserted mid-cycle during WAIT.
    issue_req(1'b0, 16'h1010, 16'h0000, 10, t);
    s = cyc;
    at_cycle(s + 3);
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_vals("midrst");
    txq.delete();
    hold_rdata = 16'h0000;
    hold_fault = 1'b0;
    last_r     = -1;
    step(2);
    reset  = 1'b0;
    chk_en = 1'b1;
    issue_req(1'b0, 16'h1004, 16'h0000, 0, t);
    s = cyc;
    at_cycle(s + 2);
    check("post_rst_rdata", 32'(bus.resp_rdata), 32'h1234);

    // Randomized traffic: mixed stores/loads, stalls up to and past the timeout.
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  hi;
      logic [15:0] addr;
      int          d;
      int          sel;
      hi   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h1;
      addr = {hi, 12'($urandom_range(0, 7))};
      sel  = $urandom_range(0, 9);
      if (sel < 6)       d = $urandom_range(0, 3);
      else if (sel == 6) d = 14;
      else if (sel == 7) d = 15;
      else if (sel == 8) d = 255;
      else               d = $urandom_range(4, 13);
      step($urandom_range(0, 2));
      issue_req(1'($urandom), addr, 16'($urandom), d, t);
    end

    at_cycle(last_r + 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
